pl0_stack_core: RTL and testbench

Parametrised execution core for the PL/0 machine: an evaluation stack, ALU and character I/O unit driven by a valid/ready instruction stream. It sits between the instruction fetch/decode front end and the character I/O device. It extends the fixed 8-bit machine with:
- configurable data width and stack depth,
- backpressured instruction and character handshakes,
- sticky overflow, underflow and illegal-opcode flags that halt the core.

---
 rtl/pl0_stack_core_if.sv | 24 ++
 rtl/pl0_stack_core.sv | 265 ++++++++++++++++++++++++++
 tb/tb_pl0_stack_core.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pl0_stack_core_if.sv
// Instruction stream and character I/O handshakes of the PL/0 execution core.
interface pl0_stack_core_if;
   logic [15:0] instruction;
   logic        instr_valid;
   logic        instr_ready;
   logic [7:0]  char_in;
   logic        char_in_valid;
   logic        char_in_ready;
   logic [7:0]  char_out;
   logic        char_out_valid;
   logic        char_out_ready;

   // Fetch/decode front end and character device side.
   modport master (
      output instruction, instr_valid, char_in, char_in_valid, char_out_ready,
      input  instr_ready, char_in_ready, char_out, char_out_valid
   );

   // Execution core side.
   modport slave (
      input  instruction, instr_valid, char_in, char_in_valid, char_out_ready,
      output instr_ready, char_in_ready, char_out, char_out_valid
   );
endinterface

// File: rtl/pl0_stack_core.sv
// PL/0 execution core: evaluation stack, ALU and character I/O unit fed by a
// valid/ready instruction stream. The top of stack is held in tos_r; the
// entries below it live in mem_r, entry i at index i (0 is the bottom).
module pl0_stack_core #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 16,
   parameter int SP_W   = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   pl0_stack_core_if.slave   bus,
   output logic [DATA_W-1:0] tos,
   output logic [SP_W-1:0]   sp,
   output logic              overflow,
   output logic              underflow,
   output logic              illegal,
   output logic              halted
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int SH_W  = $clog2(DATA_W);

   // Opcodes, instruction[15:12].
   localparam logic [3:0] OP_LIT = 4'h0;
   localparam logic [3:0] OP_OPR = 4'h1;
   localparam logic [3:0] OP_IN  = 4'h2;
   localparam logic [3:0] OP_OUT = 4'h3;

   // OPR functions, instruction[11:0]. Function 0 is not defined.
   localparam logic [11:0] OPR_ADD = 12'd1;
   localparam logic [11:0] OPR_SUB = 12'd2;
   localparam logic [11:0] OPR_AND = 12'd3;
   localparam logic [11:0] OPR_OR  = 12'd4;
   localparam logic [11:0] OPR_XOR = 12'd5;
   localparam logic [11:0] OPR_LSH = 12'd6;
   localparam logic [11:0] OPR_RSH = 12'd7;
   localparam logic [11:0] OPR_LT  = 12'd8;
   localparam logic [11:0] OPR_LTE = 12'd9;
   localparam logic [11:0] OPR_EQ  = 12'd10;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_IN_WAIT  = 2'd1,
      ST_OUT_WAIT = 2'd2,
      ST_HALT     = 2'd3
   } state_t;

   // Binary ALU: a is next-on-stack, b is top-of-stack.
   function automatic logic [DATA_W-1:0] alu_f(
      input logic [11:0]       func,
      input logic [DATA_W-1:0] a,
      input logic [DATA_W-1:0] b
   );
      logic [DATA_W-1:0] r;
      logic              big;
      big = (b >= DATA_W'(DATA_W));
      case (func)
         OPR_ADD: r = a + b;
         OPR_SUB: r = a - b;
         OPR_AND: r = a & b;
         OPR_OR:  r = a | b;
         OPR_XOR: r = a ^ b;
         OPR_LSH: r = big ? {DATA_W{1'b0}} : (a << b[SH_W-1:0]);
         OPR_RSH: r = big ? {DATA_W{1'b0}} : (a >> b[SH_W-1:0]);
         OPR_LT:  r = {{(DATA_W-1){1'b0}}, (a <  b)};
         OPR_LTE: r = {{(DATA_W-1){1'b0}}, (a <= b)};
         OPR_EQ:  r = {{(DATA_W-1){1'b0}}, (a == b)};
         default: r = {DATA_W{1'b0}};
      endcase
      return r;
   endfunction

   // True for every OPR function the ALU implements.
   function automatic logic opr_legal_f(input logic [11:0] func);
      logic ok;
      case (func)
         OPR_ADD, OPR_SUB, OPR_AND, OPR_OR, OPR_XOR,
         OPR_LSH, OPR_RSH, OPR_LT, OPR_LTE, OPR_EQ: ok = 1'b1;
         default:                                   ok = 1'b0;
      endcase
      return ok;
   endfunction

   state_t            state_r, state_s;
   logic [DATA_W-1:0] tos_r, tos_s;
   logic [SP_W-1:0]   sp_r, sp_s;
   logic              ovf_r, ovf_s;
   logic              unf_r, unf_s;
   logic              ill_r, ill_s;
   logic              halted_r;
   logic [7:0]        char_out_r, char_out_s;
   logic              instr_ready_r;
   logic              char_in_ready_r;
   logic              char_out_valid_r;
   logic [DATA_W-1:0] mem_r [DEPTH];
   logic              mem_we_s;

   logic [3:0]        opcode_s;
   logic [11:0]       operand_s;
   logic              accept_s, in_hs_s, out_hs_s;
   logic              full_s, has1_s, has2_s;
   logic [SP_W-1:0]   sp_p1_s, sp_m1_s;
   logic [PTR_W-1:0]  push_idx_s, nos_idx_s;
   logic [DATA_W-1:0] nos_s;

   assign opcode_s   = bus.instruction[15:12];
   assign operand_s  = bus.instruction[11:0];
   assign accept_s   = bus.instr_valid & instr_ready_r;
   assign in_hs_s    = bus.char_in_valid & char_in_ready_r;
   assign out_hs_s   = char_out_valid_r & bus.char_out_ready;
   assign full_s     = (sp_r == SP_W'(DEPTH));
   assign has1_s     = (sp_r != {SP_W{1'b0}});
   assign has2_s     = (sp_r >= SP_W'(2));
   assign sp_p1_s    = sp_r + SP_W'(1);
   assign sp_m1_s    = sp_r - SP_W'(1);
   // Old top moves to slot sp-1 on a push; next-on-stack sits at slot sp-2.
   assign push_idx_s = sp_r[PTR_W-1:0] - PTR_W'(1);
   assign nos_idx_s  = sp_r[PTR_W-1:0] - PTR_W'(2);
   assign nos_s      = mem_r[nos_idx_s];

   // Next state and datapath: errors are caught at accept and leave the stack untouched.
   always_comb begin
      state_s    = state_r;
      tos_s      = tos_r;
      sp_s       = sp_r;
      ovf_s      = ovf_r;
      unf_s      = unf_r;
      ill_s      = ill_r;
      char_out_s = char_out_r;
      mem_we_s   = 1'b0;
      case (state_r)
         ST_RUN: begin
            if (accept_s) begin
               case (opcode_s)
                  OP_LIT: begin
                     if (full_s) begin
                        ovf_s   = 1'b1;
                        state_s = ST_HALT;
                     end else begin
                        mem_we_s = has1_s;
                        tos_s    = DATA_W'(operand_s);
                        sp_s     = sp_p1_s;
                     end
                  end
                  OP_OPR: begin
                     if (!opr_legal_f(operand_s)) begin
                        ill_s   = 1'b1;
                        state_s = ST_HALT;
                     end else if (!has2_s) begin
                        unf_s   = 1'b1;
                        state_s = ST_HALT;
                     end else begin
                        tos_s = alu_f(operand_s, nos_s, tos_r);
                        sp_s  = sp_m1_s;
                     end
                  end
                  OP_IN: begin
                     if (full_s) begin
                        ovf_s   = 1'b1;
                        state_s = ST_HALT;
                     end else begin
                        state_s = ST_IN_WAIT;
                     end
                  end
                  OP_OUT: begin
                     if (!has1_s) begin
                        unf_s   = 1'b1;
                        state_s = ST_HALT;
                     end else begin
                        char_out_s = tos_r[7:0];
                        tos_s      = has2_s ? nos_s : {DATA_W{1'b0}};
                        sp_s       = sp_m1_s;
                        state_s    = ST_OUT_WAIT;
                     end
                  end
                  default: begin
                     ill_s   = 1'b1;
                     state_s = ST_HALT;
                  end
               endcase
            end else begin
               state_s = ST_RUN;
            end
         end
         ST_IN_WAIT: begin
            if (in_hs_s) begin
               mem_we_s = has1_s;
               tos_s    = DATA_W'(bus.char_in);
               sp_s     = sp_p1_s;
               state_s  = ST_RUN;
            end else begin
               state_s = ST_IN_WAIT;
            end
         end
         ST_OUT_WAIT: begin
            if (out_hs_s) begin
               state_s = ST_RUN;
            end else begin
               state_s = ST_OUT_WAIT;
            end
         end
         ST_HALT: begin
            state_s = ST_HALT;
         end
         default: begin
            state_s = ST_RUN;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_RUN;
      end else begin
         state_r <= state_s;
      end
   end

   // Visible stack state, sticky flags and registered handshake outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         tos_r            <= {DATA_W{1'b0}};
         sp_r             <= {SP_W{1'b0}};
         ovf_r            <= 1'b0;
         unf_r            <= 1'b0;
         ill_r            <= 1'b0;
         halted_r         <= 1'b0;
         char_out_r       <= 8'h00;
         instr_ready_r    <= 1'b0;
         char_in_ready_r  <= 1'b0;
         char_out_valid_r <= 1'b0;
      end else begin
         tos_r            <= tos_s;
         sp_r             <= sp_s;
         ovf_r            <= ovf_s;
         unf_r            <= unf_s;
         ill_r            <= ill_s;
         halted_r         <= ovf_s | unf_s | ill_s;
         char_out_r       <= char_out_s;
         instr_ready_r    <= (state_s == ST_RUN);
         char_in_ready_r  <= (state_s == ST_IN_WAIT);
         char_out_valid_r <= (state_s == ST_OUT_WAIT);
      end
   end

   // Stack body below the top; not reset, only slots 0..sp-2 are meaningful.
   always_ff @(posedge clk) begin
      if (mem_we_s && !reset) begin
         mem_r[push_idx_s] <= tos_r;
      end
   end

   assign bus.instr_ready    = instr_ready_r;
   assign bus.char_in_ready  = char_in_ready_r;
   assign bus.char_out       = char_out_r;
   assign bus.char_out_valid = char_out_valid_r;
   assign tos                = tos_r;
   assign sp                 = sp_r;
   assign overflow           = ovf_r;
   assign underflow          = unf_r;
   assign illegal            = ill_r;
   assign halted             = halted_r;

endmodule

// File: tb/tb_pl0_stack_core.sv
// Bench for pl0_stack_core with DATA_W=16, DEPTH=4. A queue-based reference
// stack predicts tos/sp/flags/instr_ready after every step; predictions go to
// a scoreboard queue and are popped when the DUT result is sampled.
module tb_pl0_stack_core;
   localparam int DW    = 16;
   localparam int DEPTH = 4;
   localparam int SPW   = 3;

   localparam logic [3:0]  OP_LIT  = 4'h0;
   localparam logic [3:0]  OP_OPR  = 4'h1;
   localparam logic [3:0]  OP_IN   = 4'h2;
   localparam logic [3:0]  OP_OUT  = 4'h3;
   localparam logic [3:0]  OP_BAD  = 4'hF;
   localparam logic [11:0] OPR_ADD = 12'd1;
   localparam logic [11:0] OPR_SUB = 12'd2;
   localparam logic [11:0] OPR_AND = 12'd3;
   localparam logic [11:0] OPR_OR  = 12'd4;
   localparam logic [11:0] OPR_XOR = 12'd5;
   localparam logic [11:0] OPR_LSH = 12'd6;
   localparam logic [11:0] OPR_RSH = 12'd7;
   localparam logic [11:0] OPR_LT  = 12'd8;
   localparam logic [11:0] OPR_LTE = 12'd9;
   localparam logic [11:0] OPR_EQ  = 12'd10;

   typedef struct {
      logic [15:0] tos;
      int          sp;
      logic        ovf;
      logic        unf;
      logic        ill;
      logic        rdy;
   } obs_t;

   logic           clk = 1'b0;
   logic           reset;
   logic [DW-1:0]  tos;
   logic [SPW-1:0] sp;
   logic           overflow, underflow, illegal, halted;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [15:0] mstk[$];
   logic [7:0]  exp_chr[$];
   obs_t        exp_q[$];
   logic        m_ovf, m_unf, m_ill, m_busy;

   pl0_stack_core_if bus_if ();

   pl0_stack_core #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus_if),
      .tos       (tos),
      .sp        (sp),
      .overflow  (overflow),
      .underflow (underflow),
      .illegal   (illegal),
      .halted    (halted)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [15:0] ref_alu(input logic [11:0] f, input logic [15:0] a,
                                           input logic [15:0] b);
      case (f)
         OPR_ADD: return a + b;
         OPR_SUB: return a - b;
         OPR_AND: return a & b;
         OPR_OR:  return a | b;
         OPR_XOR: return a ^ b;
         OPR_LSH: return (b >= 16'd16) ? 16'h0000 : 16'(a << b);
         OPR_RSH: return (b >= 16'd16) ? 16'h0000 : (a >> b);
         OPR_LT:  return (a <  b) ? 16'd1 : 16'd0;
         OPR_LTE: return (a <= b) ? 16'd1 : 16'd0;
         OPR_EQ:  return (a == b) ? 16'd1 : 16'd0;
         default: return 16'h0000;
      endcase
   endfunction

   function automatic void model_exec(input logic [3:0] op, input logic [11:0] arg);
      logic [15:0] a, b;
      case (op)
         OP_LIT: if (mstk.size() == DEPTH) m_ovf = 1'b1; else mstk.push_back(16'(arg));
         OP_OPR: begin
            if (arg < OPR_ADD || arg > OPR_EQ) m_ill = 1'b1;
            else if (mstk.size() < 2) m_unf = 1'b1;
            else begin
               b = mstk.pop_back();
               a = mstk.pop_back();
               mstk.push_back(ref_alu(arg, a, b));
            end
         end
         OP_IN: if (mstk.size() == DEPTH) m_ovf = 1'b1; else m_busy = 1'b1;
         OP_OUT: begin
            if (mstk.size() == 0) m_unf = 1'b1;
            else begin
               a = mstk.pop_back();
               exp_chr.push_back(a[7:0]);
               m_busy = 1'b1;
            end
         end
         default: m_ill = 1'b1;
      endcase
   endfunction

   function automatic void push_obs();
      obs_t o;
      o.tos = (mstk.size() > 0) ? mstk[$] : 16'h0000;
      o.sp  = mstk.size();
      o.ovf = m_ovf;
      o.unf = m_unf;
      o.ill = m_ill;
      o.rdy = !(m_ovf || m_unf || m_ill) && !m_busy;
      exp_q.push_back(o);
   endfunction

   task automatic check_obs(input string tag);
      obs_t o;
      o = exp_q.pop_front();
      check_val({tag, ".tos"}, 32'(tos), 32'(o.tos));
      check_val({tag, ".sp"}, 32'(sp), 32'(o.sp));
      check_val({tag, ".overflow"}, 32'(overflow), 32'(o.ovf));
      check_val({tag, ".underflow"}, 32'(underflow), 32'(o.unf));
      check_val({tag, ".illegal"}, 32'(illegal), 32'(o.ill));
      check_val({tag, ".halted"}, 32'(halted), 32'(o.ovf | o.unf | o.ill));
      check_val({tag, ".instr_ready"}, 32'(bus_if.instr_ready), 32'(o.rdy));
   endtask

   // Called at a falling edge; returns at the falling edge after the accept.
   task automatic issue(input logic [3:0] op, input logic [11:0] arg, input string tag);
      int n;
      n = 0;
      while (bus_if.instr_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_val({tag, ".accept"}, 32'(bus_if.instr_ready), 32'd1);
      bus_if.instruction = {op, arg};
      bus_if.instr_valid = 1'b1;
      @(posedge clk);
      model_exec(op, arg);
      push_obs();
      @(negedge clk);
      bus_if.instr_valid = 1'b0;
      check_obs(tag);
   endtask

   task automatic do_reset();
      reset                = 1'b1;
      bus_if.instr_valid   = 1'b0;
      bus_if.char_in_valid = 1'b0;
      bus_if.char_out_ready = 1'b0;
      @(negedge clk);
      check_val("rst.instr_ready", 32'(bus_if.instr_ready), 32'd0);
      check_val("rst.char_out_valid", 32'(bus_if.char_out_valid), 32'd0);
      check_val("rst.char_in_ready", 32'(bus_if.char_in_ready), 32'd0);
      check_val("rst.char_out", 32'(bus_if.char_out), 32'd0);
      check_val("rst.sp", 32'(sp), 32'd0);
      reset = 1'b0;
      mstk.delete();
      exp_chr.delete();
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
      m_ill  = 1'b0;
      m_busy = 1'b0;
      push_obs();
      @(negedge clk);
      check_obs("rst.release");
   endtask

   task automatic do_in(input logic [7:0] c, input int late, input string tag);
      issue(OP_IN, 12'h000, tag);
      for (int k = 0; k < late; k++) begin
         check_val({tag, ".char_in_ready"}, 32'(bus_if.char_in_ready), 32'd1);
         check_val({tag, ".wait_instr_ready"}, 32'(bus_if.instr_ready), 32'd0);
         @(negedge clk);
      end
      bus_if.char_in       = c;
      bus_if.char_in_valid = 1'b1;
      @(posedge clk);
      mstk.push_back(16'(c));
      m_busy = 1'b0;
      push_obs();
      @(negedge clk);
      bus_if.char_in_valid = 1'b0;
      check_obs({tag, ".push"});
      check_val({tag, ".char_in_ready_off"}, 32'(bus_if.char_in_ready), 32'd0);
   endtask

   task automatic do_out(input int stall, input string tag);
      logic [7:0] exp_c;
      bus_if.char_out_ready = 1'b0;
      issue(OP_OUT, 12'h000, tag);
      check_val({tag, ".valid"}, 32'(bus_if.char_out_valid), 32'd1);
      for (int k = 0; k < stall; k++) begin
         @(negedge clk);
         check_val({tag, ".hold"}, 32'(bus_if.char_out), 32'(exp_chr[0]));
         check_val({tag, ".hold_valid"}, 32'(bus_if.char_out_valid), 32'd1);
         check_val({tag, ".hold_instr_ready"}, 32'(bus_if.instr_ready), 32'd0);
      end
      exp_c = exp_chr.pop_front();
      check_val({tag, ".char_out"}, 32'(bus_if.char_out), 32'(exp_c));
      bus_if.char_out_ready = 1'b1;
      @(posedge clk);
      m_busy = 1'b0;
      push_obs();
      @(negedge clk);
      bus_if.char_out_ready = 1'b0;
      check_val({tag, ".valid_off"}, 32'(bus_if.char_out_valid), 32'd0);
      check_obs({tag, ".done"});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: run still active at 200000, expected earlier finish");
      $fatal(1);
   end

   initial begin
      reset                 = 1'b1;
      bus_if.instruction    = 16'h0000;
      bus_if.instr_valid    = 1'b0;
      bus_if.char_in        = 8'h00;
      bus_if.char_in_valid  = 1'b0;
      bus_if.char_out_ready = 1'b0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
      m_ill  = 1'b0;
      m_busy = 1'b0;
      do_reset();

      // Arithmetic, including wrap on subtraction.
      issue(OP_LIT, 12'd42, "lit42");
      issue(OP_LIT, 12'd58, "lit58");
      issue(OP_OPR, OPR_ADD, "add");
      check_val("add.is100", 32'(tos), 32'd100);
      issue(OP_LIT, 12'd3, "lit3");
      issue(OP_OPR, OPR_SUB, "sub");
      check_val("sub.is97", 32'(tos), 32'd97);
      issue(OP_LIT, 12'd0, "lit0");
      issue(OP_LIT, 12'd1, "lit1");
      issue(OP_OPR, OPR_SUB, "sub_wrap");
      check_val("sub_wrap.isffff", 32'(tos), 32'h0000_FFFF);

      // Shifts, logic and compares.
      do_reset();
      issue(OP_LIT, 12'd4, "l4");   issue(OP_LIT, 12'd2, "l2");  issue(OP_OPR, OPR_LSH, "lsh");
      check_val("lsh.is16", 32'(tos), 32'd16);
      issue(OP_LIT, 12'd16, "l16"); issue(OP_LIT, 12'd2, "l2");  issue(OP_OPR, OPR_RSH, "rsh");
      check_val("rsh.is4", 32'(tos), 32'd4);
      issue(OP_LIT, 12'd1, "l1");   issue(OP_LIT, 12'd16, "l16"); issue(OP_OPR, OPR_LSH, "lsh_big");
      check_val("lsh_big.is0", 32'(tos), 32'd0);
      issue(OP_OPR, OPR_OR, "or");
      issue(OP_OPR, OPR_ADD, "add20");
      issue(OP_LIT, 12'd5, "l5");   issue(OP_LIT, 12'd5, "l5");  issue(OP_OPR, OPR_LTE, "lte");
      check_val("lte.is1", 32'(tos), 32'd1);
      issue(OP_LIT, 12'd5, "l5");   issue(OP_LIT, 12'd5, "l5");  issue(OP_OPR, OPR_LT, "lt");
      check_val("lt.is0", 32'(tos), 32'd0);
      issue(OP_OPR, OPR_EQ, "eq");
      issue(OP_LIT, 12'hABC, "labc"); issue(OP_OPR, OPR_XOR, "xor");
      issue(OP_LIT, 12'hF0F, "lf0f"); issue(OP_OPR, OPR_AND, "and");
      issue(OP_OPR, OPR_LT, "lt2");
      issue(OP_LIT, 12'd15, "l15"); issue(OP_OPR, OPR_LSH, "lsh15");
      check_val("lsh15.is8000", 32'(tos), 32'h0000_8000);
      issue(OP_LIT, 12'd16, "l16"); issue(OP_OPR, OPR_RSH, "rsh_big");

      // Character I/O; char_in_valid outside IN_WAIT must not be consumed.
      do_reset();
      bus_if.char_in       = 8'h55;
      bus_if.char_in_valid = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check_val("stray_in.ready", 32'(bus_if.char_in_ready), 32'd0);
         check_val("stray_in.sp", 32'(sp), 32'd0);
      end
      bus_if.char_in_valid = 1'b0;
      do_in(8'h41, 3, "in41");
      check_val("in41.is41", 32'(tos), 32'h41);
      do_out(4, "out41");
      check_val("out41.sp0", 32'(sp), 32'd0);
      do_in(8'h7A, 0, "in7a");
      do_out(0, "out7a");

      // Stack limits.
      do_reset();
      for (int i = 1; i <= DEPTH; i++) issue(OP_LIT, 12'(i), "fill");
      check_val("fill.sp4", 32'(sp), 32'd4);
      issue(OP_LIT, 12'd5, "lit_over");
      check_val("over.flag", 32'(overflow), 32'd1);
      repeat (2) @(negedge clk);
      check_val("over.halt_holds", 32'(bus_if.instr_ready), 32'd0);
      do_reset();
      for (int i = 1; i <= DEPTH; i++) issue(OP_LIT, 12'(i + 8), "fill2");
      issue(OP_IN, 12'h000, "in_over");

      // Underflow and illegal.
      do_reset();
      issue(OP_LIT, 12'd9, "l9");
      issue(OP_OPR, OPR_ADD, "add_under");
      check_val("under.tos9", 32'(tos), 32'd9);
      do_reset();
      issue(OP_OUT, 12'h000, "out_under");
      do_reset();
      issue(OP_BAD, 12'h123, "bad_op");
      check_val("bad_op.flag", 32'(illegal), 32'd1);
      do_reset();
      issue(OP_LIT, 12'd1, "l1"); issue(OP_LIT, 12'd2, "l2");
      issue(OP_OPR, 12'd0, "bad_fn");

      // Reset while an output character is pending.
      do_reset();
      issue(OP_LIT, 12'h033, "l33");
      bus_if.char_out_ready = 1'b0;
      issue(OP_OUT, 12'h000, "out_abort");
      check_val("out_abort.valid", 32'(bus_if.char_out_valid), 32'd1);
      do_reset();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
